aes_256_decrypt_iter: RTL

- Iterative AES-256 decryption core (FIPS-197 inverse cipher); the receive-side counterpart of the team's pipelined AES-256 encryptor.
- Loads a 256-bit key once and expands it internally into 15 stored round keys.
- Decrypts one 128-bit block per 14 rounds, at one round per clock.
- Uses valid/ready handshakes on key, ciphertext and plaintext.
- Byte order matches the encryptor: byte 0 is in the MSBs (state[127:120], key[255:248]).

---
 rtl/aes_256_decrypt_iter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_256_decrypt_iter.sv
// Iterative AES-256 inverse cipher: one round per clock, 15 stored round keys.
// Byte 0 of every 128-bit block sits in bits [127:120]; key word w0 in [255:224].
module aes_256_decrypt_iter (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [255:0] key_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] ciphertext_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] plaintext_o,
    output logic         key_loaded_o
);

    typedef enum logic [2:0] {IDLE, KEYEXP, READY, DECRYPT, DONE} state_t;

    state_t       fsm_q;
    logic [3:0]   idx_q;          // next round-key index in KEYEXP, round number in DECRYPT
    logic [127:0] st_q;
    logic [127:0] pt_q;
    logic         out_valid_q;
    logic         key_loaded_q;
    logic [127:0] rk_q [0:15];    // entries 0..14 used; 16 deep so a 4-bit index never runs off the end

    logic [127:0] ke_prev;
    logic [31:0]  ke_last;
    logic [31:0]  ke_temp;
    logic [127:0] ke_new;
    logic [127:0] rd_sub;
    logic [127:0] rd_mix;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) product, used only to build the multiplicative inverse
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    // Forward S-box: inverse followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map followed by the inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Row r of column c comes from column c-r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Multiply by a small constant through an xtime chain; c folds away at each call site
    function automatic logic [7:0] gmul_c(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul_c(a0, 4'he) ^ gmul_c(a1, 4'hb) ^ gmul_c(a2, 4'hd) ^ gmul_c(a3, 4'h9);
            o[119-32*c -: 8] = gmul_c(a0, 4'h9) ^ gmul_c(a1, 4'he) ^ gmul_c(a2, 4'hb) ^ gmul_c(a3, 4'hd);
            o[111-32*c -: 8] = gmul_c(a0, 4'hd) ^ gmul_c(a1, 4'h9) ^ gmul_c(a2, 4'he) ^ gmul_c(a3, 4'hb);
            o[103-32*c -: 8] = gmul_c(a0, 4'hb) ^ gmul_c(a1, 4'hd) ^ gmul_c(a2, 4'h9) ^ gmul_c(a3, 4'he);
        end
        return o;
    endfunction

    assign key_ready_o  = (fsm_q == IDLE) || (fsm_q == READY);
    assign in_ready_o   = (fsm_q == READY) && !key_valid_i;
    assign out_valid_o  = out_valid_q;
    assign plaintext_o  = pt_q;
    assign key_loaded_o = key_loaded_q;

    // Next round key from the two previous ones, and one inverse round on the state
    always_comb begin
        ke_prev = rk_q[idx_q - 4'd2];
        ke_last = rk_q[idx_q - 4'd1][31:0];
        if (idx_q[0])
            ke_temp = sub_word(ke_last);
        else
            ke_temp = sub_word({ke_last[23:0], ke_last[31:24]})
                      ^ {8'h01 << (idx_q[3:1] - 3'd1), 24'h000000};
        ke_new[127:96] = ke_prev[127:96] ^ ke_temp;
        ke_new[95:64]  = ke_prev[95:64]  ^ ke_new[127:96];
        ke_new[63:32]  = ke_prev[63:32]  ^ ke_new[95:64];
        ke_new[31:0]   = ke_prev[31:0]   ^ ke_new[63:32];
        rd_sub = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_q[idx_q];
        rd_mix = inv_mix_columns(rd_sub);
    end

    // Round-key file: key halves on accept, then one expanded key per KEYEXP cycle
    always_ff @(posedge clk_i) begin
        if (key_valid_i && key_ready_o) begin
            rk_q[0] <= key_i[255:128];
            rk_q[1] <= key_i[127:0];
        end else if (fsm_q == KEYEXP) begin
            rk_q[idx_q] <= ke_new;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q        <= IDLE;
            idx_q        <= 4'd0;
            st_q         <= '0;
            pt_q         <= '0;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (key_valid_i) begin
                        fsm_q        <= KEYEXP;
                        idx_q        <= 4'd2;
                        key_loaded_q <= 1'b0;
                    end
                end
                KEYEXP: begin
                    if (idx_q == 4'd14) begin
                        fsm_q        <= READY;
                        key_loaded_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                READY: begin
                    if (key_valid_i) begin
                        fsm_q        <= KEYEXP;
                        idx_q        <= 4'd2;
                        key_loaded_q <= 1'b0;
                    end else if (in_valid_i) begin
                        st_q  <= ciphertext_i ^ rk_q[14];
                        idx_q <= 4'd13;
                        fsm_q <= DECRYPT;
                    end
                end
                DECRYPT: begin
                    if (idx_q == 4'd0) begin
                        pt_q        <= rd_sub;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        st_q  <= rd_mix;
                        idx_q <= idx_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= READY;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule
